imem_read_responder: RTL and testbench

- Responder end of the fetch-to-instruction-memory read handshake. Fetch drives mem_readEn and mem_read_addr; this block answers with readFin and mem_read_data.
- Holds a word-organised instruction store with a fixed, parameterised access latency, and a load port used for program preload.
- Sits between the fetch stage and the on-chip instruction RAM and replaces any ideal zero-latency memory model.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_word_ram.sv | 27 ++
 rtl/imem_read_responder.sv | 136 +++++++++++++
 tb/tb_imem_read_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory read responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } imem_state_e;

    // Width of a word index into a store of 'depth' words (at least one bit).
    function automatic int unsigned word_idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Word-organised instruction store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; they are filled through the preload port.
module imem_word_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int IDXW  = 10
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [IDXW-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [IDXW-1:0] raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Preload write; a read of the same word at this edge still sees the old value.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_read_responder.sv
// Responder end of the fetch-to-instruction-memory read handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for mem_readEn; the only state that accepts requests
//   BUSY  | request latched, latency counter running down
//   RESP  | readFin high for this single cycle, then back to IDLE
//
// The address is assumed wider than the word index plus the two byte bits,
// so any set bit above the index marks the request as out of range.
module imem_read_responder
    import imem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int READ_ADDR_SIZE = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int LATENCY        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_readEn,
    input  logic [READ_ADDR_SIZE-1:0]    mem_read_addr,
    input  logic                         flush,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]              load_data,
    output logic                         readFin,
    output logic [XLEN-1:0]              mem_read_data,
    output logic                         mem_addr_err,
    output logic                         busy
);

    localparam int IDXW  = word_idx_width(MEM_DEPTH);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    imem_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [READ_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [XLEN-1:0]           rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic [READ_ADDR_SIZE-1:0] rd_addr;
    logic [IDXW-1:0]           rd_idx;
    logic                      rd_err;
    logic [XLEN-1:0]           ram_rdata;
    logic [XLEN-1:0]           rd_word;

    // With LATENCY=1 the array is read on the accept edge, before addr_q holds the address.
    assign rd_addr = (state_q == IDLE) ? mem_read_addr : addr_q;
    assign rd_idx  = rd_addr[IDXW+1:2];
    assign rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr[READ_ADDR_SIZE-1:IDXW+2] != '0);
    assign rd_word = rd_err ? '0 : ram_rdata;

    imem_word_ram #(
        .XLEN  (XLEN),
        .DEPTH (MEM_DEPTH),
        .IDXW  (IDXW)
    ) u_ram (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    // State, counter, address latch and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the response registers load only on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_readEn && !flush) begin
                    addr_d = mem_read_addr;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rdata_d = rd_word;
                        err_d   = rd_err;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RESP;
                        rdata_d = rd_word;
                        err_d   = rd_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state and response registers.
    always_comb begin
        readFin       = (state_q == RESP);
        busy          = (state_q != IDLE);
        mem_read_data = rdata_q;
        mem_addr_err  = err_q;
    end

endmodule

// File: tb/tb_imem_read_responder.sv
// Scoreboard bench for imem_read_responder: directed scenarios followed by random traffic.
module tb_imem_read_responder;

    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int IDXW  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             mem_readEn = 1'b0;
    logic [AW-1:0]    mem_read_addr = '0;
    logic             flush = 1'b0;
    logic             load_en = 1'b0;
    logic [IDXW-1:0]  load_addr = '0;
    logic [XLEN-1:0]  load_data = '0;
    logic             readFin;
    logic [XLEN-1:0]  mem_read_data;
    logic             mem_addr_err;
    logic             busy;

    always #5 clk = ~clk;

    imem_read_responder #(
        .XLEN           (XLEN),
        .READ_ADDR_SIZE (AW),
        .MEM_DEPTH      (DEPTH),
        .LATENCY        (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_readEn    (mem_readEn),
        .mem_read_addr (mem_read_addr),
        .flush         (flush),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .readFin       (readFin),
        .mem_read_data (mem_read_data),
        .mem_addr_err  (mem_addr_err),
        .busy          (busy)
    );

    typedef struct {
        int          e0;
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } req_t;

    req_t        sb_q[$];
    req_t        new_r;
    logic [31:0] mem_model [DEPTH];
    int          cyc = 0;
    int          free_edge = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_data = '0;
    logic        last_err = 1'b0;
    logic        exp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one outstanding request, response due LAT-1 edges after acceptance,
    // next acceptance possible LAT+1 edges later; flush while waiting abandons it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            sb_q.delete();
            free_edge = cyc + 1;
        end else begin
            if (flush && sb_q.size() > 0 && cyc > sb_q[0].e0 && cyc <= sb_q[0].due) begin
                sb_q.delete(0);
                free_edge = cyc + 1;
            end
            if (mem_readEn && !flush && cyc >= free_edge) begin
                new_r.e0   = cyc;
                new_r.due  = cyc + LAT - 1;
                new_r.addr = mem_read_addr;
                new_r.err  = (mem_read_addr[1:0] != 2'b00) ||
                             ({32'b0, mem_read_addr} >= 64'(DEPTH) * 64'd4);
                new_r.data = '0;
                sb_q.push_back(new_r);
                free_edge = cyc + LAT + 1;
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc)
                sb_q[0].data = sb_q[0].err ? 32'h0 : mem_model[sb_q[0].addr[IDXW+1:2]];
        end
        if (load_en) mem_model[load_addr] = load_data;
    end

    // Monitor: compare every cycle's handshake against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            exp_busy = (sb_q.size() > 0);
            check("busy", busy, exp_busy);
            if (readFin) begin
                if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
                    check("readFin_unexpected", readFin, 0);
                end else begin
                    check("rdata", mem_read_data, sb_q[0].data);
                    check("err", mem_addr_err, sb_q[0].err);
                    last_data = sb_q[0].data;
                    last_err  = sb_q[0].err;
                    sb_q.delete(0);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check("readFin_missing", readFin, 1);
                sb_q.delete(0);
            end else begin
                check("hold_data", mem_read_data, last_data);
                check("hold_err", mem_addr_err, last_err);
            end
        end else begin
            last_data = '0;
            last_err  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_read(input logic [31:0] a);
        mem_readEn    = 1'b1;
        mem_read_addr = a;
        tick();
        mem_readEn = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1:       return 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            2:       return {$urandom_range(1, 255) > 0 ? 8'hFF : 8'h01, 24'($urandom_range(0, 1023) * 4)};
            default: return 32'($urandom_range(0, 63) * 4);
        endcase
    endfunction

    initial begin
        int n_resp;

        // Reset state
        repeat (3) tick();
        check("rst_readFin", readFin, 0);
        check("rst_data", mem_read_data, 0);
        check("rst_err", mem_addr_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // Preload the low 64 words
        for (int i = 0; i < 64; i++) begin
            load_en   = 1'b1;
            load_addr = 10'(i);
            load_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            tick();
        end
        load_en = 1'b0;
        tick();

        // Single pulse to word 5
        pulse_read(32'h14);

        // Held request, address stepping after each response
        mem_read_addr = 32'h0;
        mem_readEn    = 1'b1;
        n_resp        = 0;
        for (int k = 0; k < 20 && n_resp < 3; k++) begin
            tick();
            if (readFin) begin
                n_resp++;
                mem_read_addr = mem_read_addr + 32'd4;
            end
        end
        mem_readEn = 1'b0;
        check("stream_count", n_resp, 3);
        repeat (4) tick();

        // Request dropped right after acceptance still completes
        pulse_read(32'h8);

        // Flush during BUSY abandons, next request served normally
        mem_readEn    = 1'b1;
        mem_read_addr = 32'h14;
        tick();
        mem_readEn = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        repeat (3) tick();
        pulse_read(32'h10);

        // Address errors
        pulse_read(32'h6);
        pulse_read(32'(DEPTH * 4));
        pulse_read(32'hFFFF_FFFC);

        // Asynchronous reset mid-BUSY
        mem_readEn    = 1'b1;
        mem_read_addr = 32'h14;
        tick();
        mem_readEn = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_readFin", readFin, 0);
        check("async_data", mem_read_data, 0);
        check("async_err", mem_addr_err, 0);
        check("async_busy", busy, 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        // Load on the RESP-entry edge returns old data, a later read sees the new word
        mem_readEn    = 1'b1;
        mem_read_addr = 32'h1C;
        tick();
        mem_readEn = 1'b0;
        load_en    = 1'b1;
        load_addr  = 10'd7;
        load_data  = 32'hCAFEF00D;
        tick();
        load_en = 1'b0;
        repeat (3) tick();
        pulse_read(32'h1C);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            mem_readEn    = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 19) == 0);
            load_en       = ($urandom_range(0, 9) == 0);
            load_addr     = 10'($urandom_range(0, 63));
            load_data     = $urandom;
            mem_read_addr = rand_addr();
            tick();
        end
        mem_readEn = 1'b0;
        flush      = 1'b0;
        load_en    = 1'b0;
        repeat (6) tick();
        check("queue_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
